// File: rtl/id_ex_hazard_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage_if
//
// Purpose:
//   Bundles every signal exchanged between the ID/EX pipeline register with
//   load-use hazard detection and its surroundings. The decoded ID-stage
//   instruction and the flush request flow in, while the registered EX-stage
//   copies, the fetch/IF-ID hold enables and the stall counter flow out.
//
// Modports:
//   master : the surrounding pipeline (drives ID fields and PCSrc, observes
//            EX fields, hold enables and STALL_CNT)
//   slave  : the id_ex_hazard_stage block itself
//
// Signal summary:
//   PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID   32-bit decoded operands
//   FUNCT3_ID (3), FUNCT7_ID (7), OPCODE_ID (7), RD_ID/RS1_ID/RS2_ID (5)
//   PCSrc                                        taken branch -> flush
//   *_EX                                         registered copies + control
//   PC_write, IF_ID_write                        1 = advance, 0 = hold
//   STALL_CNT                                    load-use bubbles inserted
// -----------------------------------------------------------------------------
interface id_ex_hazard_stage_if #(
    parameter int STALL_CNT_W = 16
);
    // ID-stage inputs
    logic [31:0]            PC_ID;
    logic [31:0]            IMM_ID;
    logic [31:0]            REG_DATA1_ID;
    logic [31:0]            REG_DATA2_ID;
    logic [2:0]             FUNCT3_ID;
    logic [6:0]             FUNCT7_ID;
    logic [6:0]             OPCODE_ID;
    logic [4:0]             RD_ID;
    logic [4:0]             RS1_ID;
    logic [4:0]             RS2_ID;
    logic                   PCSrc;

    // EX-stage registered data
    logic [31:0]            PC_EX;
    logic [31:0]            IMM_EX;
    logic [31:0]            REG_DATA1_EX;
    logic [31:0]            REG_DATA2_EX;
    logic [2:0]             FUNCT3_EX;
    logic [6:0]             FUNCT7_EX;
    logic [4:0]             RD_EX;
    logic [4:0]             RS1_EX;
    logic [4:0]             RS2_EX;

    // EX-stage registered control
    logic                   RegWrite_EX;
    logic                   MemRead_EX;
    logic                   MemWrite_EX;
    logic                   MemtoReg_EX;
    logic                   ALUSrc_EX;
    logic                   Branch_EX;
    logic [1:0]             ALUOp_EX;

    // Hold enables and statistics
    logic                   PC_write;
    logic                   IF_ID_write;
    logic [STALL_CNT_W-1:0] STALL_CNT;

    modport master (
        output PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID,
        output FUNCT3_ID, FUNCT7_ID, OPCODE_ID, RD_ID, RS1_ID, RS2_ID,
        output PCSrc,
        input  PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
        input  FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX,
        input  RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX,
        input  ALUSrc_EX, Branch_EX, ALUOp_EX,
        input  PC_write, IF_ID_write, STALL_CNT
    );

    modport slave (
        input  PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID,
        input  FUNCT3_ID, FUNCT7_ID, OPCODE_ID, RD_ID, RS1_ID, RS2_ID,
        input  PCSrc,
        output PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
        output FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX,
        output RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX,
        output ALUSrc_EX, Branch_EX, ALUOp_EX,
        output PC_write, IF_ID_write, STALL_CNT
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
//
// Purpose:
//   ID/EX pipeline register for a 5-stage RV32 integer core, combined with the
//   control decoder and the load-use hazard unit.
//   - Decodes OPCODE_ID into the EX-stage control bits.
//   - Detects a load in EX whose destination feeds a source actually used by
//     the instruction in ID; in that case fetch and IF/ID are held for one
//     cycle and a bubble (all control zero) is loaded into EX.
//   - A taken branch (PCSrc) also loads a bubble but never holds fetch; it
//     wins over a simultaneous load-use hazard.
//   - STALL_CNT counts load-use bubbles only, wrapping at 2^STALL_CNT_W.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset; clears every register
//   bus    : id_ex_hazard_stage_if.slave (ID inputs, EX outputs, hold
//            enables, stall counter)
//
// Parameters:
//   STALL_CNT_W : width of the load-use bubble counter
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    id_ex_hazard_stage_if.slave   bus
);

    // RV32I major opcodes handled by the decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // ---------------------------------------------------------------------
    // Registered EX-stage state
    // ---------------------------------------------------------------------
    logic [31:0]            r_pc_ex;
    logic [31:0]            r_imm_ex;
    logic [31:0]            r_data1_ex;
    logic [31:0]            r_data2_ex;
    logic [2:0]             r_funct3_ex;
    logic [6:0]             r_funct7_ex;
    logic [4:0]             r_rd_ex;
    logic [4:0]             r_rs1_ex;
    logic [4:0]             r_rs2_ex;

    logic                   r_regwrite_ex;
    logic                   r_memread_ex;
    logic                   r_memwrite_ex;
    logic                   r_memtoreg_ex;
    logic                   r_alusrc_ex;
    logic                   r_branch_ex;
    logic [1:0]             r_aluop_ex;

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // ---------------------------------------------------------------------
    // Combinational decode of the ID-stage instruction
    // ---------------------------------------------------------------------
    logic                   w_regwrite;
    logic                   w_memread;
    logic                   w_memwrite;
    logic                   w_memtoreg;
    logic                   w_alusrc;
    logic                   w_branch;
    logic [1:0]             w_aluop;
    logic                   w_rs1_used;
    logic                   w_rs2_used;

    always_comb begin
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = ALUOP_ADD;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (bus.OPCODE_ID)
            OP_R: begin
                w_regwrite = 1'b1;
                w_aluop    = ALUOP_FUNC;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OP_I_ALU: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = ALUOP_FUNC;
                w_rs1_used = 1'b1;
            end
            OP_LOAD: begin
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = ALUOP_ADD;
                w_rs1_used = 1'b1;
            end
            OP_STORE: begin
                w_memwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = ALUOP_ADD;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                w_branch   = 1'b1;
                w_aluop    = ALUOP_BR;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: begin
                // Unsupported opcode: leave every control bit low so it
                // behaves as a NOP and reads no register.
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Load-use hazard detection
    // ---------------------------------------------------------------------
    // x0 is hard-wired to zero, so a load targeting it never produces a
    // value anyone must wait for. Field matches only count when the ID
    // instruction actually reads that source; an I-type's rs2 bits are
    // immediate bits and must not trigger a stall.
    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hazard;
    logic w_stall;
    logic w_bubble;

    assign w_rs1_match = w_rs1_used && (r_rd_ex == bus.RS1_ID);
    assign w_rs2_match = w_rs2_used && (r_rd_ex == bus.RS2_ID);
    assign w_hazard    = r_memread_ex && (r_rd_ex != 5'd0) &&
                         (w_rs1_match || w_rs2_match);

    // A taken branch discards the ID instruction anyway, so holding fetch
    // for it would only delay the redirect.
    assign w_stall  = w_hazard && !bus.PCSrc;
    assign w_bubble = w_hazard || bus.PCSrc;

    assign bus.PC_write    = !w_stall;
    assign bus.IF_ID_write = !w_stall;

    // ---------------------------------------------------------------------
    // ID -> EX register boundary
    // ---------------------------------------------------------------------
    // Data fields always follow ID; inside a bubble they are ignored because
    // no control bit is set, so gating them would only cost logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_ex       <= '0;
            r_imm_ex      <= '0;
            r_data1_ex    <= '0;
            r_data2_ex    <= '0;
            r_funct3_ex   <= '0;
            r_funct7_ex   <= '0;
            r_rd_ex       <= '0;
            r_rs1_ex      <= '0;
            r_rs2_ex      <= '0;
            r_regwrite_ex <= 1'b0;
            r_memread_ex  <= 1'b0;
            r_memwrite_ex <= 1'b0;
            r_memtoreg_ex <= 1'b0;
            r_alusrc_ex   <= 1'b0;
            r_branch_ex   <= 1'b0;
            r_aluop_ex    <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_pc_ex     <= bus.PC_ID;
            r_imm_ex    <= bus.IMM_ID;
            r_data1_ex  <= bus.REG_DATA1_ID;
            r_data2_ex  <= bus.REG_DATA2_ID;
            r_funct3_ex <= bus.FUNCT3_ID;
            r_funct7_ex <= bus.FUNCT7_ID;
            r_rd_ex     <= bus.RD_ID;
            r_rs1_ex    <= bus.RS1_ID;
            r_rs2_ex    <= bus.RS2_ID;

            if (w_bubble) begin
                r_regwrite_ex <= 1'b0;
                r_memread_ex  <= 1'b0;
                r_memwrite_ex <= 1'b0;
                r_memtoreg_ex <= 1'b0;
                r_alusrc_ex   <= 1'b0;
                r_branch_ex   <= 1'b0;
                r_aluop_ex    <= '0;
            end else begin
                r_regwrite_ex <= w_regwrite;
                r_memread_ex  <= w_memread;
                r_memwrite_ex <= w_memwrite;
                r_memtoreg_ex <= w_memtoreg;
                r_alusrc_ex   <= w_alusrc;
                r_branch_ex   <= w_branch;
                r_aluop_ex    <= w_aluop;
            end

            // Only load-use bubbles are counted; natural wrap is intended.
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output drive
    // ---------------------------------------------------------------------
    assign bus.PC_EX        = r_pc_ex;
    assign bus.IMM_EX       = r_imm_ex;
    assign bus.REG_DATA1_EX = r_data1_ex;
    assign bus.REG_DATA2_EX = r_data2_ex;
    assign bus.FUNCT3_EX    = r_funct3_ex;
    assign bus.FUNCT7_EX    = r_funct7_ex;
    assign bus.RD_EX        = r_rd_ex;
    assign bus.RS1_EX       = r_rs1_ex;
    assign bus.RS2_EX       = r_rs2_ex;

    assign bus.RegWrite_EX  = r_regwrite_ex;
    assign bus.MemRead_EX   = r_memread_ex;
    assign bus.MemWrite_EX  = r_memwrite_ex;
    assign bus.MemtoReg_EX  = r_memtoreg_ex;
    assign bus.ALUSrc_EX    = r_alusrc_ex;
    assign bus.Branch_EX    = r_branch_ex;
    assign bus.ALUOp_EX     = r_aluop_ex;

    assign bus.STALL_CNT    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//
// Scoreboard bench for id_ex_hazard_stage. The stimulus process drives one
// instruction per cycle, predicts the result from an instruction-level model
// and queues it; a separate monitor compares hold enables before the edge and
// the EX register contents / stall counter after it. A narrow counter is used
// so wrap-around is reached within a short run.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

    localparam int CW = 3;

    logic clk;
    logic reset;

    id_ex_hazard_stage_if #(.STALL_CNT_W(CW)) bus_if ();

    id_ex_hazard_stage #(.STALL_CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Instruction-level reference model
    // ---------------------------------------------------------------------
    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_OTHER} kind_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } instr_t;

    typedef struct {
        logic          pcw;
        logic [7:0]    ctrl;
        logic [152:0]  data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Instruction currently sitting in EX, as the model sees it
    logic [7:0] m_ctrl;   // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp}
    logic [4:0] m_rd;
    int         m_cnt;

    int n_pass  = 0;
    int n_total = 0;

    function automatic kind_t kind_of(logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            default:    return K_OTHER;
        endcase
    endfunction

    function automatic logic [6:0] op_of(kind_t k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            default: return ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b1101111;
        endcase
    endfunction

    function automatic logic [7:0] ctrl_of(kind_t k);
        case (k)
            K_R:     return 8'b1000_0010;
            K_I:     return 8'b1000_1010;
            K_LD:    return 8'b1101_1000;
            K_ST:    return 8'b0010_1000;
            K_BR:    return 8'b0000_0101;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic bit reads_rs1(kind_t k);
        return k != K_OTHER && k != K_I ? 1'b1 : (k == K_I);
    endfunction

    function automatic bit reads_rs2(kind_t k);
        return (k == K_R) || (k == K_ST) || (k == K_BR);
    endfunction

    function automatic logic [152:0] data_of(instr_t in);
        return {in.pc, in.imm, in.d1, in.d2, in.f3, in.f7, in.rd, in.rs1, in.rs2};
    endfunction

    function automatic instr_t mk(kind_t k, int rd, int rs1, int rs2);
        instr_t in;
        in.pc  = $urandom();
        in.imm = $urandom();
        in.d1  = $urandom();
        in.d2  = $urandom();
        in.f3  = 3'($urandom());
        in.f7  = 7'($urandom());
        in.op  = op_of(k);
        in.rd  = 5'(rd);
        in.rs1 = 5'(rs1);
        in.rs2 = 5'(rs2);
        return in;
    endfunction

    task automatic model_reset();
        m_ctrl = 8'h00;
        m_rd   = 5'd0;
        m_cnt  = 0;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic drive(input instr_t in, input logic pcsrc);
        bus_if.PC_ID        = in.pc;
        bus_if.IMM_ID       = in.imm;
        bus_if.REG_DATA1_ID = in.d1;
        bus_if.REG_DATA2_ID = in.d2;
        bus_if.FUNCT3_ID    = in.f3;
        bus_if.FUNCT7_ID    = in.f7;
        bus_if.OPCODE_ID    = in.op;
        bus_if.RD_ID        = in.rd;
        bus_if.RS1_ID       = in.rs1;
        bus_if.RS2_ID       = in.rs2;
        bus_if.PCSrc        = pcsrc;
    endtask

    // Present one instruction, queue the predicted outcome, and return just
    // after the capturing edge.
    task automatic issue(input instr_t in, input logic pcsrc, output bit stalled);
        kind_t k;
        bit    hazard;
        exp_t  e;
        drive(in, pcsrc);
        k      = kind_of(in.op);
        hazard = m_ctrl[6] && (m_rd != 5'd0) &&
                 ((m_rd == in.rs1 && reads_rs1(k)) || (m_rd == in.rs2 && reads_rs2(k)));
        stalled = hazard && !pcsrc;
        if (stalled) m_cnt++;
        m_ctrl = (hazard || pcsrc) ? 8'h00 : ctrl_of(k);
        m_rd   = in.rd;
        e.pcw  = !stalled;
        e.ctrl = m_ctrl;
        e.data = data_of(in);
        e.cnt  = CW'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] act_ctrl();
        return {bus_if.RegWrite_EX, bus_if.MemRead_EX, bus_if.MemWrite_EX,
                bus_if.MemtoReg_EX, bus_if.ALUSrc_EX, bus_if.Branch_EX, bus_if.ALUOp_EX};
    endfunction

    function automatic logic [152:0] act_data();
        return {bus_if.PC_EX, bus_if.IMM_EX, bus_if.REG_DATA1_EX, bus_if.REG_DATA2_EX,
                bus_if.FUNCT3_EX, bus_if.FUNCT7_EX, bus_if.RD_EX, bus_if.RS1_EX, bus_if.RS2_EX};
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_ctrl"}, 160'(act_ctrl()), 160'(0));
        chk({tag, "_data"}, 160'(act_data()), 160'(0));
        chk({tag, "_cnt"}, 160'(bus_if.STALL_CNT), 160'(0));
        chk({tag, "_pc_write"}, 160'(bus_if.PC_write), 160'(1));
        chk({tag, "_if_id_write"}, 160'(bus_if.IF_ID_write), 160'(1));
    endtask

    // ---------------------------------------------------------------------
    // Monitor: hold enables mid-cycle, registered state after the edge
    // ---------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("pc_write", 160'(bus_if.PC_write), 160'(e.pcw));
                chk("if_id_write", 160'(bus_if.IF_ID_write), 160'(e.pcw));
            end
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ex_ctrl", 160'(act_ctrl()), 160'(e.ctrl));
                chk("ex_data", 160'(act_data()), 160'(e.data));
                chk("stall_cnt", 160'(bus_if.STALL_CNT), 160'(e.cnt));
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        bit     st;
        instr_t cur;
        instr_t tmp;
        bit     hold;

        model_reset();
        reset = 1'b0;
        drive(mk(K_LD, 9, 1, 2), 1'b0);
        #3;
        check_cleared("rst");
        @(posedge clk);
        #1;
        check_cleared("rst_edge");
        #2;
        reset = 1'b1;

        // R-type add x3,x1,x2
        issue(mk(K_R, 3, 1, 2), 1'b0, st);
        // Load x5, dependent add on rs1: one stall, then the add proceeds
        issue(mk(K_LD, 5, 1, 0), 1'b0, st);
        cur = mk(K_R, 6, 5, 2);
        issue(cur, 1'b0, st);
        issue(cur, 1'b0, st);
        // Load to x0 followed by a reader of x0: no stall
        issue(mk(K_LD, 0, 1, 0), 1'b0, st);
        issue(mk(K_R, 8, 0, 0), 1'b0, st);
        // Load x7 then store reading x7 through rs2: stall
        issue(mk(K_LD, 7, 2, 0), 1'b0, st);
        cur = mk(K_ST, 0, 3, 7);
        issue(cur, 1'b0, st);
        issue(cur, 1'b0, st);
        // Load x7 then I-ALU whose rs2 field is 7 (not a read): no stall
        issue(mk(K_LD, 7, 2, 0), 1'b0, st);
        issue(mk(K_I, 9, 3, 7), 1'b0, st);
        // Hazard coinciding with a taken branch: flush wins, no count
        issue(mk(K_LD, 4, 2, 0), 1'b0, st);
        issue(mk(K_R, 10, 4, 4), 1'b1, st);
        issue(mk(K_BR, 0, 4, 4), 1'b0, st);

        // Randomized traffic with the IF/ID hold honoured
        hold = 1'b0;
        cur  = mk(K_R, 1, 1, 1);
        for (int i = 0; i < 250; i++) begin
            if (!hold) begin
                cur = mk(kind_t'($urandom_range(0, 5)), $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 4));
                if ($urandom_range(0, 2) == 0) cur.op = op_of(K_LD);
            end
            issue(cur, ($urandom_range(0, 7) == 0), st);
            hold = st;
        end

        // Reset asserted between edges while a load-use stall is pending
        issue(mk(K_LD, 5, 1, 0), 1'b0, st);
        tmp = mk(K_R, 11, 5, 1);
        drive(tmp, 1'b0);
        #1;
        chk("stall_before_rst", 160'(bus_if.PC_write), 160'(0));
        #1;
        reset = 1'b0;
        #1;
        check_cleared("rst_mid");
        @(posedge clk);
        #1;
        check_cleared("rst_mid_edge");
        #1;
        reset = 1'b1;
        model_reset();

        hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!hold) begin
                cur = mk(kind_t'($urandom_range(0, 5)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) cur.op = op_of(K_LD);
            end
            issue(cur, ($urandom_range(0, 9) == 0), st);
            hold = st;
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 160'(sb.size()), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset.
REQ-002 Parameter SHALL be STALL_CNT_W, default 16, the width of the stall counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID  in  32 each  decoded ID-stage operands.
REQ-006 FUNCT3_ID  in  3 / FUNCT7_ID, OPCODE_ID  in  7 / RD_ID, RS1_ID, RS2_ID  in  5  decoded fields.
REQ-007 PCSrc  in  1  taken branch from a later stage; flush request.
REQ-008 PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX  out  same widths  registered copies.
REQ-009 RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX  out  1  registered control; ALUOp_EX  out  2.
REQ-010 PC_write, IF_ID_write  out  1  combinational hold enables to fetch and IF/ID register; 1 = advance.
REQ-011 STALL_CNT  out  STALL_CNT_W  count of inserted load-use bubbles.

Function
REQ-012 The control decode from OPCODE_ID SHALL be: 0110011 -> RegWrite, ALUOp=10; 0010011 -> RegWrite, ALUSrc, ALUOp=10; 0000011 -> RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00; 0100011 -> MemWrite, ALUSrc, ALUOp=00; 1100011 -> Branch, ALUOp=01; any other opcode -> all controls 0.
REQ-013 rs1 SHALL count as used for the R, I-ALU, load, store and branch opcodes; rs2 SHALL count as used for the R, store and branch opcodes.
REQ-014 A load-use hazard SHALL be: MemRead_EX=1, RD_EX!=0, and (RD_EX==RS1_ID with rs1 used, or RD_EX==RS2_ID with rs2 used).
REQ-015 On a hazard with PCSrc=0, the block SHALL drive PC_write=0 and IF_ID_write=0 in the same cycle.
REQ-016 On a hazard with PCSrc=0, the next edge SHALL load a bubble: all control outputs 0; the data outputs are don't-care but SHALL take the ID values.
REQ-017 On the cycle after a bubble, the hazard SHALL clear because MemRead_EX=0, so each load-use pair costs exactly one bubble.
REQ-018 PCSrc=1 SHALL load a bubble on the next edge, drive PC_write=1 and IF_ID_write=1, and suppress the stall; PCSrc SHALL take priority over the hazard.
REQ-019 With no hazard and PCSrc=0, the next edge SHALL register all ID inputs and the decoded control, giving a latency of 1 cycle.
REQ-020 STALL_CNT SHALL increment by 1 at each edge where a load-use bubble is inserted.
REQ-021 STALL_CNT SHALL wrap modulo 2^STALL_CNT_W.
REQ-022 PCSrc-caused bubbles SHALL NOT increment STALL_CNT.
REQ-023 A bubble SHALL never raise RegWrite_EX, MemWrite_EX or MemRead_EX.

Reset
REQ-024 reset=0 SHALL immediately clear every registered output and STALL_CNT to 0, independent of clk.
REQ-025 During reset, PC_write=1 and IF_ID_write=1, since MemRead_EX=0 means no hazard.
REQ-026 Assertion of reset mid-stall SHALL abandon the stall.
REQ-027 The first edge after reset=1 SHALL capture the ID inputs normally.

Verification
REQ-028 Scenario: R-type add x3,x1,x2 (OPCODE 0110011, RD=3) -> one edge later RegWrite_EX=1, ALUOp_EX=10, RD_EX=3, PC_EX=PC_ID; PC_write=1 throughout.
REQ-029 Scenario: load with RD=5, then add with RS1=5 -> PC_write=IF_ID_write=0 for 1 cycle, then a bubble in EX (all controls 0), STALL_CNT=1; the add enters EX one cycle later.
REQ-030 Scenario: load with RD=0, then a consumer with RS1=0 -> no stall, STALL_CNT unchanged.
REQ-031 Scenario: load with RD=7, then a store with RS2=7 -> stall; load with RD=7, then I-ALU with RS2 field=7 (rs2 unused) -> no stall.
REQ-032 Scenario: hazard and PCSrc=1 in the same cycle -> PC_write=1, bubble inserted, STALL_CNT unchanged.
REQ-033 Scenario: reset=0 asserted between clock edges while a stall is in progress -> all outputs 0 at once, PC_write=1; after release, normal capture and STALL_CNT counting from 0.
